cacheline_adaptor: RTL and testbench

//  Bridges the arbiter's 256-bit cacheline port (pmem_*) to physical memory's 64-bit burst port (mem_*).
//  A line read or write becomes one 4-beat burst; the adaptor buffers the line and returns a single-cycle pmem_resp.

---
 rtl/cacheline_adaptor_pkg.sv | 25 ++
 rtl/cacheline_adaptor.sv | 168 ++++++++++++++++
 tb/tb_cacheline_adaptor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared types and sizes for the cacheline adaptor
//
// Purpose: line/beat geometry, burst length, timeout limit and the FSM state
//          type used by cacheline_adaptor.
// Ports:   none (package).
package cacheline_adaptor_pkg;

  localparam int LINE_W         = 256;
  localparam int BEAT_W         = 64;
  localparam int BURST_LEN      = LINE_W / BEAT_W;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } cla_state_t;

  // Aligns a byte address down to the start of its 32-byte line.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & 32'hFFFF_FFE0;
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cacheline port to 64-bit 4-beat burst memory bridge
//
// Purpose: turns one line read/write from the arbiter into a single 4-beat
//          memory burst, buffers the line and returns a one-cycle pmem_resp.
// Build option: CLA_TIMEOUT_EN adds a beat-gap watchdog and the pmem_err port.
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   pmem_read, pmem_write          line requests from the arbiter
//   pmem_address [31:0]            byte address, any offset
//   pmem_wdata   [255:0]           line to write
//   pmem_rdata   [255:0]           assembled line, valid while pmem_resp=1
//   pmem_resp                      one-cycle completion pulse
//   mem_read, mem_write            burst strobes, held until the 4th beat
//   mem_address  [31:0]            line-aligned burst address
//   mem_wdata    [63:0]            current write beat
//   mem_rdata    [63:0]            current read beat
//   mem_resp                       beat accepted/valid this cycle
//   pmem_err                       sticky timeout flag (CLA_TIMEOUT_EN only)
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
`ifdef CLA_TIMEOUT_EN
  ,
  output logic              pmem_err
`endif
);

  cla_state_t        state;
  cla_state_t        state_next;
  logic [1:0]        count;
  logic [LINE_W-1:0] line_buf;
  logic [31:0]       line_addr;
  logic              last_beat;
  logic              timeout;
  logic [7:0]        beat_lsb;

  assign beat_lsb  = {count, 6'b0};
  assign last_beat = mem_resp && (count == 2'(BURST_LEN - 1));

`ifdef CLA_TIMEOUT_EN
  // Gap counter restarts on every beat; hitting the limit with no beat in
  // the same cycle means memory has stalled for TIMEOUT_CYCLES cycles.
  logic [9:0] gap;

  assign timeout = ((state == READ) || (state == WRITE)) && !mem_resp &&
                   (gap == 10'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap      <= '0;
      pmem_err <= 1'b0;
    end else begin
      if ((state == READ) || (state == WRITE)) begin
        gap <= mem_resp ? '0 : gap + 10'd1;
      end else begin
        gap <= '0;
      end
      if (timeout) begin
        pmem_err <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a simultaneous read and write is served write-first
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pmem_write) begin
          state_next = WRITE;
        end else if (pmem_read) begin
          state_next = READ;
        end
      end
      READ, WRITE: begin
        if (last_beat || timeout) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode from state only, so reset clears the strobes immediately
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    pmem_resp   = 1'b0;
    pmem_rdata  = '0;
    mem_address = line_addr;
    case (state)
      READ:  mem_read = 1'b1;
      WRITE: begin
        mem_write = 1'b1;
        mem_wdata = line_buf[beat_lsb +: BEAT_W];
      end
      DONE: begin
        pmem_resp  = 1'b1;
        pmem_rdata = line_buf;
      end
      default: ;
    endcase
  end

  // Datapath: request capture in IDLE, beat counting and read assembly.
  // Request inputs are only looked at in IDLE, so mid-burst changes are moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      line_buf  <= '0;
      line_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          count <= '0;
          if (pmem_write) begin
            line_buf  <= pmem_wdata;
            line_addr <= line_base(pmem_address);
          end else if (pmem_read) begin
            line_addr <= line_base(pmem_address);
          end
        end
        READ: begin
          if (mem_resp) begin
            line_buf[beat_lsb +: BEAT_W] <= mem_rdata;
            count                        <= count + 2'd1;
          end
        end
        WRITE: begin
          if (mem_resp) begin
            count <= count + 2'd1;
          end
        end
        DONE:    count <= '0;
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - randomized self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;
`ifdef CLA_TIMEOUT_EN
  logic         pmem_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
`ifdef CLA_TIMEOUT_EN
    ,
    .pmem_err     (pmem_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // One complete line transaction against a memory model that waits
  // gap_min..gap_max cycles before each beat. For reads 'line' is what memory
  // returns beat by beat; for writes it is the line the arbiter sends.
  task automatic run_txn(input bit do_wr, input bit both, input logic [31:0] addr,
                         input logic [255:0] line, input int gap_min, input int gap_max);
    logic [31:0] exp_addr;
    int b;
    int wait_n;
    int cyc;
    exp_addr     = {addr[31:5], 5'b0};
    b            = 0;
    cyc          = 0;
    pmem_address = addr;
    pmem_wdata   = do_wr ? line : rand_line();
    pmem_write   = do_wr;
    pmem_read    = !do_wr || both;
    wait_n       = $urandom_range(gap_max, gap_min);
    while (b < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check("mem_read_held", mem_read, !do_wr);
      check("mem_write_held", mem_write, do_wr);
      check("mem_address", mem_address, exp_addr);
      check("no_early_resp", pmem_resp, 1'b0);
      // Only the IDLE-sampled copy may matter from here on.
      pmem_address = $urandom;
      pmem_wdata   = rand_line();
      if (wait_n == 0) begin
        if (do_wr) check("mem_wdata_beat", mem_wdata, line[b*64 +: 64]);
        mem_resp  = 1'b1;
        mem_rdata = line[b*64 +: 64];
        b++;
        wait_n = $urandom_range(gap_max, gap_min);
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = {$urandom, $urandom};
        wait_n--;
      end
    end
    check("beats_done", b, 4);
    @(negedge clk);
    mem_resp = 1'b0;
    check("resp_after_last_beat", pmem_resp, 1'b1);
    check("mem_read_dropped", mem_read, 1'b0);
    check("mem_write_dropped", mem_write, 1'b0);
    if (!do_wr) check("read_line", pmem_rdata, line);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
    check("resp_single_pulse", pmem_resp, 1'b0);
  endtask

  initial begin
    logic [255:0] line;
    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pmem_resp", pmem_resp, 1'b0);
    check("rst_pmem_rdata", pmem_rdata, '0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, '0);
    check("rst_mem_wdata", mem_wdata, '0);
`ifdef CLA_TIMEOUT_EN
    check("rst_pmem_err", pmem_err, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_txn(1'b0, 1'b0, 32'h0000_1000, line, 0, 0);
    line = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    run_txn(1'b1, 1'b0, 32'h0000_2040, line, 0, 0);
    run_txn(1'b0, 1'b0, 32'h0000_123C, rand_line(), 0, 1);
    run_txn(1'b1, 1'b1, 32'h0000_4008, rand_line(), 0, 1);
    run_txn(1'b0, 1'b0, 32'h0000_4008, rand_line(), 3, 3);

    // Stray mem_resp while idle must not advance the beat counter
    repeat (3) begin
      @(negedge clk);
      mem_resp = 1'b1;
    end
    @(negedge clk);
    mem_resp = 1'b0;
    check("idle_no_resp", pmem_resp, 1'b0);
    check("idle_no_read", mem_read, 1'b0);
    run_txn(1'b0, 1'b0, 32'h0000_5000, rand_line(), 0, 2);

    // Reset after the second beat: strobe drops at once, next read is clean
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_6000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = {$urandom, $urandom};
    end
    @(negedge clk);
    mem_resp = 1'b0;
    check("pre_rst_mem_read", mem_read, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_mem_read", mem_read, 1'b0);
    pmem_read = 1'b0;
    @(negedge clk);
    check("rst_hold_resp", pmem_resp, 1'b0);
    check("rst_hold_rdata", pmem_rdata, '0);
    rst = 1'b0;
    run_txn(1'b0, 1'b0, 32'h0000_6000, rand_line(), 0, 0);

    // Randomized traffic
    for (int t = 0; t < 16; t++) begin
      run_txn(1'($urandom_range(1, 0)), ($urandom_range(7, 0) == 0),
              $urandom, rand_line(), 0, 3);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

`ifdef CLA_TIMEOUT_EN
    begin
      int cyc;
      check("err_clear_before", pmem_err, 1'b0);
      line         = rand_line();
      pmem_read    = 1'b1;
      pmem_address = 32'h0000_3000;
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = line[63:0];
      cyc = 0;
      do begin
        @(negedge clk);
        mem_resp = 1'b0;
        cyc++;
      end while (!pmem_resp && cyc < 1100);
      check("to_resp", pmem_resp, 1'b1);
      check("to_err", pmem_err, 1'b1);
      check("to_partial_beat0", pmem_rdata[63:0], line[63:0]);
      check("to_gap_window", (cyc >= 1024 && cyc <= 1026), 1'b1);
      pmem_read = 1'b0;
      @(negedge clk);
      check("to_single_pulse", pmem_resp, 1'b0);
      check("to_err_sticky", pmem_err, 1'b1);
      check("to_idle", mem_read, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("to_err_cleared", pmem_err, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
